// File: rtl/pos_cell_access_ctrl_if.sv
// Signal bundle between the position cache logic, one cell RAM and the access controller.
interface pos_cell_access_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  stream_start;
  logic                  stream_busy;
  logic                  stream_valid;
  logic [DATA_WIDTH-1:0] stream_data;
  logic [ADDR_WIDTH-1:0] stream_id;
  logic                  stream_last;
  logic [ADDR_WIDTH-1:0] stream_count;
  logic                  stream_done;
  logic                  count_err;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  // master: the controller, which owns the RAM pins
  modport master (
    input  stream_start, wr_req, wr_addr, wr_data, mem_q,
    output stream_busy, stream_valid, stream_data, stream_id, stream_last,
           stream_count, stream_done, count_err, wr_ack,
           mem_address, mem_data, mem_rden, mem_wren
  );

  modport slave (
    output stream_start, wr_req, wr_addr, wr_data, mem_q,
    input  stream_busy, stream_valid, stream_data, stream_id, stream_last,
           stream_count, stream_done, count_err, wr_ack,
           mem_address, mem_data, mem_rden, mem_wren
  );
endinterface

// File: rtl/pos_cell_access_ctrl.sv
// Shares one cell position RAM port between the full-cell fetch stream and the writeback path.
module pos_cell_access_ctrl #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220
) (
  input logic                    clk,
  input logic                    rst,
  pos_cell_access_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] rd_id, count_q, rd_addr, raw_count, clamped_count;
  logic                  count_err_q, prev_wr, rd_pending, wr_win, rd_win;
  logic                  count_ret, overflow;
  logic                  tag_cnt;
  logic [ADDR_WIDTH-1:0] tag_id;
  logic [1:0]            pipe_valid, pipe_cnt;
  logic [ADDR_WIDTH-1:0] pipe_id [2];
  logic                  mem_rden_q, mem_wren_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  // Arbitration: a pending read yields to a write unless the previous grant was already a write
  always_comb begin
    rd_pending    = (state == CNT_RD) || (state == STREAM);
    wr_win        = bus.wr_req && !rst && (!rd_pending || !prev_wr);
    rd_win        = rd_pending && !wr_win;
    rd_addr       = (state == CNT_RD) ? '0 : rd_id;
    raw_count     = bus.mem_q[ADDR_WIDTH-1:0];
    overflow      = raw_count > MAX_COUNT;
    clamped_count = overflow ? MAX_COUNT : raw_count;
    count_ret     = pipe_valid[1] && pipe_cnt[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.stream_start) state_next = CNT_RD;
      CNT_RD:   if (rd_win) state_next = CNT_WAIT;
      CNT_WAIT: if (count_ret) state_next = (clamped_count != '0) ? STREAM : DONE;
      STREAM:   if (rd_win && (rd_id == count_q)) state_next = DRAIN;
      // the last read is already on mem_q once the presented and first tracking stages are empty
      DRAIN:    if (!mem_rden_q && !pipe_valid[0]) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.stream_busy  = (state == CNT_RD) || (state == CNT_WAIT) ||
                       (state == STREAM) || (state == DRAIN);
    bus.stream_done  = (state == DONE);
    bus.stream_valid = pipe_valid[1] && !pipe_cnt[1];
    bus.stream_id    = bus.stream_valid ? pipe_id[1] : '0;
    bus.stream_data  = bus.stream_valid ? bus.mem_q : '0;
    bus.stream_last  = bus.stream_valid && (pipe_id[1] == count_q);
    bus.stream_count = count_q;
    bus.count_err    = count_err_q;
    bus.wr_ack       = wr_win;
    bus.mem_address  = mem_address_q;
    bus.mem_data     = mem_data_q;
    bus.mem_rden     = mem_rden_q;
    bus.mem_wren     = mem_wren_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rden_q    <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      tag_cnt       <= 1'b0;
      tag_id        <= '0;
      pipe_valid    <= '0;
      pipe_cnt      <= '0;
      pipe_id[0]    <= '0;
      pipe_id[1]    <= '0;
      prev_wr       <= 1'b0;
      rd_id         <= '0;
      count_q       <= '0;
      count_err_q   <= 1'b0;
    end else begin
      mem_rden_q <= rd_win;
      mem_wren_q <= wr_win;
      if (rd_win) begin
        mem_address_q <= rd_addr;
      end else if (wr_win) begin
        mem_address_q <= bus.wr_addr;
        mem_data_q    <= bus.wr_data;
      end
      // tag rides with the presented op; mem_rden_q is its valid bit
      tag_cnt       <= (state == CNT_RD);
      tag_id        <= rd_addr;
      pipe_valid[0] <= mem_rden_q;
      pipe_cnt[0]   <= tag_cnt;
      pipe_id[0]    <= tag_id;
      pipe_valid[1] <= pipe_valid[0];
      pipe_cnt[1]   <= pipe_cnt[0];
      pipe_id[1]    <= pipe_id[0];
      prev_wr       <= wr_win;
      if (state == CNT_RD)
        rd_id <= ADDR_WIDTH'(1);
      else if ((state == STREAM) && rd_win)
        rd_id <= rd_id + ADDR_WIDTH'(1);
      if ((state == CNT_WAIT) && count_ret) begin
        count_q <= clamped_count;
        if (overflow) count_err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Scoreboard bench for pos_cell_access_ctrl with a behavioural 2-cycle-latency RAM.
module tb_pos_cell_access_ctrl;
  localparam int unsigned DW = 96;
  localparam int unsigned AW = 8;
  localparam int unsigned PN = 220;

  typedef struct packed {
    logic [AW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } item_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pos_cell_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pos_cell_access_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PARTICLE_NUM(PN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM: op presented in cycle p, read data on mem_q in cycle p+2
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_d1;
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
    rd_d1     <= bus.mem_rden ? ram[bus.mem_address] : {$urandom, $urandom, $urandom};
    bus.mem_q <= rd_d1;
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  item_t       exp_q[$];
  wr_t         cmd_q[$];
  logic [DW-1:0] shadow [256];
  int unsigned exp_count = 0;
  logic        exp_err = 1'b0;
  logic        streaming = 1'b0;
  logic        has_wr = 1'b0;
  int unsigned start_cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned bg_pct = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] all_outputs();
    return {bus.stream_busy, bus.stream_valid, bus.stream_data, bus.stream_id, bus.stream_last,
            bus.stream_count, bus.stream_done, bus.count_err, bus.wr_ack,
            bus.mem_address, bus.mem_data, bus.mem_rden, bus.mem_wren};
  endfunction

  // Write driver: holds each request until acked; background traffic stays in 220..255
  initial begin : writer
    logic        acked;
    int unsigned waited;
    wr_t         w;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    waited      = 0;
    forever begin
      @(negedge clk);
      acked = bus.wr_req && bus.wr_ack;
      if (bus.wr_req && !acked) waited++;
      @(posedge clk);
      #1;
      if (acked) begin
        check("wr_wait_le_1", (waited > 1), 0);
        bus.wr_req = 1'b0;
        waited     = 0;
      end else if (bus.wr_req && waited > 3) begin
        check("wr_ack_timeout", 0, 1);
        bus.wr_req = 1'b0;
        waited     = 0;
      end
      if (!bus.wr_req && !rst) begin
        if (cmd_q.size() > 0) begin
          w           = cmd_q.pop_front();
          bus.wr_req  = 1'b1;
          bus.wr_addr = w.addr;
          bus.wr_data = w.data;
        end else if (bg_pct > 0 && $urandom_range(0, 99) < bg_pct) begin
          bus.wr_req  = 1'b1;
          bus.wr_addr = AW'(220 + $urandom_range(0, 35));
          bus.wr_data = rnd96();
        end
      end
    end
  end

  initial begin : monitor
    logic  pend;
    wr_t   pw;
    item_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        continue;
      end
      if (bus.mem_rden || bus.mem_wren) check("rd_wr_exclusive", bus.mem_rden & bus.mem_wren, 0);
      if (pend) begin
        check("mem_wr_op", {bus.mem_wren, bus.mem_address, bus.mem_data}, {1'b1, pw.addr, pw.data});
        pend = 1'b0;
      end else if (bus.mem_wren) begin
        check("mem_wr_unrequested", 1, 0);
      end
      if (bus.wr_ack) begin
        check("ack_has_req", bus.wr_req, 1);
        pend    = 1'b1;
        pw.addr = bus.wr_addr;
        pw.data = bus.wr_data;
        shadow[bus.wr_addr] = bus.wr_data;
        if (streaming && cyc > start_cyc) has_wr = 1'b1;
      end
      if (bus.stream_valid) begin
        check("busy_during_valid", bus.stream_busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {bus.stream_id, bus.stream_data, bus.stream_last}, e);
          if (e.id == AW'(1) && !has_wr) check("first_latency", cyc - start_cyc, 8);
        end
      end
      if (bus.stream_done) begin
        check("done_count", bus.stream_count, exp_count);
        check("done_count_err", bus.count_err, exp_err);
        check("done_remaining", exp_q.size(), 0);
        check("done_busy_low", bus.stream_busy, 0);
        if (!has_wr) check("done_latency", cyc - start_cyc, (exp_count == 0) ? 5 : 8 + exp_count);
        streaming = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic wait_writer_idle();
    for (int i = 0; i < 2000 && (cmd_q.size() != 0 || bus.wr_req); i++) begin
      @(posedge clk);
      #2;
    end
    if (cmd_q.size() != 0 || bus.wr_req) check("writer_idle_timeout", 0, 1);
  endtask

  task automatic load_cell(input int unsigned cnt, input int unsigned ndata);
    wr_t w;
    for (int unsigned k = 1; k <= ndata; k++) begin
      w.addr = AW'(k);
      w.data = rnd96();
      cmd_q.push_back(w);
    end
    w.addr = '0;
    w.data = rnd96();
    w.data[AW-1:0] = AW'(cnt);
    cmd_q.push_back(w);
    wait_writer_idle();
  endtask

  task automatic run_stream(input int unsigned bg, input bit spur, input bit mid_wr,
                            input int unsigned abort_at);
    int unsigned n;
    int unsigned d0;
    item_t       e;
    wr_t         w;
    wait_writer_idle();
    n = shadow[0][AW-1:0];
    if (n > PN - 1) begin
      n       = PN - 1;
      exp_err = 1'b1;
    end
    exp_count = n;
    for (int unsigned k = 1; k <= n; k++) begin
      e.id   = AW'(k);
      e.data = shadow[k];
      e.last = (k == n);
      exp_q.push_back(e);
    end
    has_wr = 1'b0;
    bg_pct = bg;
    d0     = done_cnt;
    @(posedge clk);
    #2;
    bus.stream_start = 1'b1;
    start_cyc        = cyc;
    streaming        = 1'b1;
    @(posedge clk);
    #2;
    bus.stream_start = 1'b0;
    if (mid_wr) begin
      repeat (4) @(posedge clk);
      #2;
      w.addr = '0;
      w.data = rnd96();
      w.data[AW-1:0] = AW'(7);
      cmd_q.push_back(w);
    end
    if (spur) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #2;
        if (bus.stream_busy) begin
          bus.stream_start = 1'b1;
          @(posedge clk);
          #2;
          bus.stream_start = 1'b0;
        end
      end
    end
    if (abort_at != 0) begin
      while (cyc < start_cyc + abort_at) begin
        @(posedge clk);
        #2;
      end
      rst       = 1'b1;
      streaming = 1'b0;
      exp_q.delete();
      exp_err   = 1'b0;
      bg_pct    = 0;
      #1;
      check("reset_mid_stream_zero", all_outputs(), 0);
      return;
    end
    for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
      @(posedge clk);
      #2;
    end
    bg_pct = 0;
    if (done_cnt == d0) begin
      check("done_timeout", 0, 1);
      streaming = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin : main
    int unsigned n;
    bus.stream_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs_zero", all_outputs(), 0);
    rst = 1'b0;

    load_cell(3, 3);    run_stream(0, 0, 0, 0);
    load_cell(0, 0);    run_stream(0, 0, 0, 0);
    load_cell(4, 4);    run_stream(100, 0, 0, 0);
    load_cell(3, 7);    run_stream(0, 0, 1, 0);
    run_stream(0, 0, 0, 0);

    repeat (12) begin
      n = $urandom_range(0, 25);
      load_cell(n, n);
      run_stream(($urandom_range(0, 1) == 1) ? $urandom_range(10, 70) : 0,
                 ($urandom_range(0, 1) == 1), 0, 0);
    end

    load_cell(250, PN - 1);
    run_stream(0, 0, 0, 0);

    load_cell(10, 10);
    run_stream(0, 0, 0, 9);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    run_stream(0, 0, 0, 0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pos_cell_access_ctrl.md
# pos_cell_access_ctrl

Access controller for one cell position RAM: 96-bit words, address 0 holds the particle count, 2-cycle read latency, single port. It shares the single RAM port between two requesters:
- the force-evaluation fetch, which streams every particle of the cell on one start command;
- the motion-update writeback, which writes individual words.

It sits between the position cache logic and one cell RAM instance, and owns all of that RAM's control pins.

## Interface
- DATA_WIDTH, 96, RAM word width {posz, posy, posx}
- ADDR_WIDTH, 8, RAM address width
- PARTICLE_NUM, 220, RAM depth; max legal count = PARTICLE_NUM-1

- clock  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- stream_start  in  1  start a full-cell stream; sampled only in IDLE
- stream_busy  out  1  high from the cycle after an accepted start until stream_done
- stream_valid  out  1  stream_data/stream_id valid
- stream_data  out  DATA_WIDTH  particle word (mem_q pass-through)
- stream_id  out  ADDR_WIDTH  particle address 1..count of stream_data
- stream_last  out  1  with stream_valid on particle id == count
- stream_count  out  ADDR_WIDTH  latched (clamped) count of the current/last stream
- stream_done  out  1  one-cycle pulse at stream end
- count_err  out  1  sticky: a count > PARTICLE_NUM-1 was read; cleared by rst only
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_ack
- wr_addr  in  ADDR_WIDTH  write address (0 permitted)
- wr_data  in  DATA_WIDTH  write data
- wr_ack  out  1  combinational grant in the cycle the write is taken
- mem_address  out  ADDR_WIDTH  registered RAM address
- mem_data  out  DATA_WIDTH  registered RAM write data
- mem_rden  out  1  registered RAM read enable
- mem_wren  out  1  registered RAM write enable
- mem_q  in  DATA_WIDTH  RAM read data

## Operation
- **States:**
  - IDLE: stream_start → CNT_RD.
  - CNT_RD: on the cycle the count read wins → CNT_WAIT.
  - CNT_WAIT: on count return → STREAM if count ≠ 0, else DONE.
  - STREAM: after the read of id == count is issued → DRAIN.
  - DRAIN: when the read pipe is empty → DONE.
  - DONE: one cycle, stream_done = 1 → IDLE.
- **Count:** count = mem_q[ADDR_WIDTH-1:0] of the address-0 read.
  - If count > PARTICLE_NUM-1: clamp to PARTICLE_NUM-1 and set count_err.
  - The count is latched once per stream. Writes to address 0 during a stream do not alter it.
- **Grant decision:** made every cycle. The RAM op is presented the next cycle via the registered mem_* outputs. At most one of mem_rden and mem_wren is high.
  - IDLE, CNT_WAIT, DRAIN, DONE: wr_req always granted.
  - CNT_RD, STREAM: a read is pending. If wr_req=1 and the previous grant was a read (or there was no grant), the write wins; otherwise the read wins. Neither side waits more than 1 cycle.
  - A non-granted cycle drives mem_rden = mem_wren = 0, with mem_address/mem_data holding their values.
- **Read tracking:** a 2-stage shift register carries {valid, is_count, id} beside each issued read, aligned to mem_q.
  - Count reads never raise stream_valid.
- **Coherence:** no ordering is guaranteed between a write and an already-issued read of the same address.
- **Reset:** any cycle, including mid-stream. All outputs 0, FSM → IDLE, read pipe flushed, count_err cleared. Data returning after reset is discarded.

## Timing
- Notation: stream_start high in IDLE cycle n; no write contention; N = latched count.
  - n+1: CNT_RD decision. n+2: mem_rden=1, mem_address=0. n+4: count on mem_q, latched.
  - Read of id k: decided n+4+k, presented n+5+k, stream_valid/stream_data at n+7+k.
  - stream_last at n+7+N. stream_done pulse at n+8+N; stream_busy low from n+8+N.
  - N = 0: stream_done at n+5, no stream_valid.
- Each write granted in CNT_RD/STREAM delays all later reads by exactly 1 cycle.
- Write: wr_ack in cycle c → mem_wren=1 with wr_addr/wr_data in c+1.
- stream_start while busy or in DONE: ignored.
- Throughput: 1 particle/cycle with no writes; ≥ 1 per 2 cycles under continuous wr_req.

## Test plan
- **Basic stream:** RAM addr0 = 3, addr1..3 = A,B,C; start at n → valid at n+8,9,10 with ids 1,2,3; last at n+10; done at n+11; count = 3.
- **Zero count:** addr0 = 0; start → done at n+5, stream_valid never high, busy high n+1..n+4.
- **Contention:** count = 4, wr_req held high throughout → grants alternate read/write; wr_ack every other cycle in STREAM; all 4 particles delivered in order; no cycle with both mem_rden and mem_wren.
- **Overflow:** addr0 = 250, PARTICLE_NUM = 220 → count_err = 1, stream_count = 219, stream_last on id 219.
- **Reset mid-stream:** assert rst at n+9 of a count-10 stream → all outputs 0 immediately. After release, stream_valid stays 0 until a new start; a new start streams correctly from id 1.
- **Write to address 0 mid-stream:** write 7 during a count-3 stream → current stream ends at id 3; the next stream reports count = 7.
